// File: rtl/mu0_dma_initiator_if.sv
// MU0 single-port memory bus plus the request/grant pair shared with the core.
// The DMA block drives the bus through the master modport; the core/memory side uses slave.
interface mu0_dma_initiator_if;
    logic        Bus_req;
    logic        Bus_gnt;
    logic        Mem_rd;
    logic        Mem_wr;
    logic [11:0] Mem_addr;
    logic [15:0] Mem_wdata;
    logic [15:0] Mem_rdata;

    modport master (
        output Bus_req, Mem_rd, Mem_wr, Mem_addr, Mem_wdata,
        input  Bus_gnt, Mem_rdata
    );

    modport slave (
        input  Bus_req, Mem_rd, Mem_wr, Mem_addr, Mem_wdata,
        output Bus_gnt, Mem_rdata
    );
endinterface

// File: rtl/mu0_dma_initiator.sv
// Block copy / block fill initiator for the MU0 memory bus.
// Requests the bus from the core, moves one word per granted cycle, then releases it.
//
// state | meaning
// IDLE  | waiting for Start; command latched and range-checked here
// REQ   | Bus_req high, waiting for Bus_gnt
// READ  | copy only: read source word into buffer (strobe gated by grant)
// WRITE | write buffer (copy) or fill value (fill) to destination
// FIN   | one-cycle Done pulse, Err if the command was rejected
module mu0_dma_initiator #(
    parameter logic [11:0] MEM_TOP = 12'hEFF
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       Start,
    input  logic                       Mode,
    input  logic [11:0]                Src_addr,
    input  logic [11:0]                Dst_addr,
    input  logic [11:0]                Length,
    input  logic [15:0]                Fill_data,
    mu0_dma_initiator_if.master        bus,
    output logic                       Busy,
    output logic                       Done,
    output logic                       Err
);

    typedef enum logic [2:0] {IDLE, REQ, READ, WRITE, FIN} state_t;

    state_t      state, state_nxt;
    logic [11:0] src, dst, cnt;
    logic [15:0] data_buf, fill_q;
    logic        mode_q, err_q;

    logic [12:0] src_last, dst_last;
    logic        reject;

    // 13-bit sums so an end address past 0xFFF cannot alias back into range.
    assign src_last = {1'b0, Src_addr} + {1'b0, Length} - 13'd1;
    assign dst_last = {1'b0, Dst_addr} + {1'b0, Length} - 13'd1;
    assign reject   = (Length != 12'd0) &&
                      ((dst_last > {1'b0, MEM_TOP}) ||
                       (!Mode && (src_last > {1'b0, MEM_TOP})));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.Bus_req   = 1'b0;
        bus.Mem_rd    = 1'b0;
        bus.Mem_wr    = 1'b0;
        bus.Mem_addr  = 12'd0;
        bus.Mem_wdata = 16'd0;
        Busy          = (state != IDLE);
        Done          = 1'b0;
        Err           = 1'b0;
        case (state)
            IDLE: begin
                if (Start)
                    state_nxt = (reject || Length == 12'd0) ? FIN : REQ;
            end
            REQ: begin
                bus.Bus_req = 1'b1;
                if (bus.Bus_gnt)
                    state_nxt = mode_q ? WRITE : READ;
            end
            READ: begin
                bus.Bus_req = 1'b1;
                bus.Mem_rd  = bus.Bus_gnt;
                if (bus.Bus_gnt) begin
                    bus.Mem_addr = src;
                    state_nxt    = WRITE;
                end
            end
            WRITE: begin
                bus.Bus_req = 1'b1;
                bus.Mem_wr  = bus.Bus_gnt;
                if (bus.Bus_gnt) begin
                    bus.Mem_addr  = dst;
                    bus.Mem_wdata = mode_q ? fill_q : data_buf;
                    if (cnt == 12'd1) state_nxt = FIN;
                    else              state_nxt = mode_q ? WRITE : READ;
                end
            end
            FIN: begin
                Done      = 1'b1;
                Err       = err_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            src      <= 12'd0;
            dst      <= 12'd0;
            cnt      <= 12'd0;
            data_buf <= 16'd0;
            fill_q   <= 16'd0;
            mode_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        src    <= Src_addr;
                        dst    <= Dst_addr;
                        cnt    <= Length;
                        mode_q <= Mode;
                        fill_q <= Fill_data;
                        err_q  <= reject;
                    end
                end
                READ: begin
                    if (bus.Bus_gnt) data_buf <= bus.Mem_rdata;
                end
                WRITE: begin
                    if (bus.Bus_gnt) begin
                        src <= src + 12'd1;
                        dst <= dst + 12'd1;
                        cnt <= cnt - 12'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
